gray_serial_decoder: RTL and testbench

Serial Gray-code receiver and decoder, the return path for the lab's 4-bit binary→Gray converter. A Gray word arrives MSB-first on a 1-bit line framed by a start strobe. The block decodes it to binary on the fly and presents the result through a one-entry valid/ready output buffer. It sits between the serial link and the binary consumer (display or LED logic) and flags words lost to back-pressure.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray_out_buf.sv | 38 +++
 rtl/gray_serial_decoder.sv | 78 +++++++
 tb/tb_gray_serial_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the serial Gray-code receiver.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_out_buf.sv
// One-entry valid/ready holding register; flags words dropped while full.
module gray_out_buf
    import gray_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] bin_out,
    output logic         out_valid,
    output logic         overrun
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // a consume in the same cycle frees the slot for the new word
                if (!out_valid || out_ready) begin
                    bin_out   <= load_data;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gray_serial_decoder.sv
// Serial MSB-first Gray receiver: decodes to binary on the fly.
module gray_serial_decoder
    import gray_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sin,
    output logic [W-1:0] bin_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int CW = $clog2(W);

    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          b;
    logic          done;
    logic [W-1:0]  word;

    assign b    = prev ^ sin;
    assign done = (state == SHIFT) && (cnt == '0);
    // acc[0] is still clear here, so OR-ing in the last bit completes it
    assign word = acc | W'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            prev  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        acc[W-1]   <= sin;
                        prev       <= sin;
                        cnt        <= CW'(W - 2);
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc[cnt] <= b;
                    prev     <= b;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    gray_out_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (done),
        .load_data (word),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_gray_serial_decoder.sv
// Scoreboard bench for gray_serial_decoder with W=4.
module tb_gray_serial_decoder;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sin;
    logic [3:0] bin_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    gray_serial_decoder #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin       (sin),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {28'd0, bin_out}, 32'hFFFF_FFFF);
            end else begin
                chk("scoreboard_word", {28'd0, bin_out},
                    {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start/g[3] in cycle 0 and g[2..0] in cycles 1..3;
    // returns #1 into cycle 4.
    task automatic send(input logic [3:0] g);
        start = 1'b1;
        sin   = g[3];
        for (int i = 2; i >= 0; i--) begin
            tick();
            start = 1'b0;
            sin   = g[i];
        end
        tick();
        start = 1'b0;
        sin   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bin"},     {28'd0, bin_out}, 32'd0);
        chk({tag, "_valid"},   {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // 1: Gray 0110 -> 0100, valid in cycle 4, gone in cycle 5
        out_ready = 1'b1;
        exp_q.push_back(4'b0100);
        send(4'b0110);
        chk("t1_valid_c4", {31'd0, out_valid}, 32'd1);
        chk("t1_bin_c4", {28'd0, bin_out}, 32'h4);
        tick();
        chk("t1_valid_c5", {31'd0, out_valid}, 32'd0);

        // 2: fixed corners then exhaustive sweep, back-to-back
        exp_q.push_back(4'b1111);
        send(4'b1000);
        chk("t2_bin_1000", {28'd0, bin_out}, 32'hF);
        exp_q.push_back(4'b0000);
        send(4'b0000);
        chk("t2_bin_0000", {28'd0, bin_out}, 32'h0);
        for (int g = 0; g < 16; g++) begin
            logic [15:0] e;
            e = gray2bin(16'(g));
            exp_q.push_back(e[3:0]);
            send(4'(g));
        end
        tick();
        tick();

        // 3: back-to-back 0001, 0011
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        send(4'b0001);
        chk("t3_valid_c4", {31'd0, out_valid}, 32'd1);
        chk("t3_bin_c4", {28'd0, bin_out}, 32'h1);
        send(4'b0011);
        chk("t3_valid_c8", {31'd0, out_valid}, 32'd1);
        chk("t3_bin_c8", {28'd0, bin_out}, 32'h2);
        chk("t3_no_overrun", {31'd0, overrun}, 32'd0);
        tick();
        tick();

        // 4: back-pressure drops the second word
        out_ready = 1'b0;
        exp_q.push_back(4'b0100);
        send(4'b0110);
        chk("t4_overrun_c4", {31'd0, overrun}, 32'd0);
        send(4'b0001);
        chk("t4_overrun_c8", {31'd0, overrun}, 32'd1);
        chk("t4_bin_kept", {28'd0, bin_out}, 32'h4);
        chk("t4_valid_kept", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t4_overrun_c9", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t4_drained", {31'd0, out_valid}, 32'd0);

        // 5: reset at cycle 2 of a frame, released at cycle 4
        start = 1'b1;
        sin   = 1'b1;
        tick();
        start = 1'b0;
        sin   = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_vals("t5_release");
        tick();
        chk_reset_vals("t5_idle");
        exp_q.push_back(4'b1111);
        send(4'b1000);
        chk("t5_bin", {28'd0, bin_out}, 32'hF);
        tick();

        // 6: start during SHIFT ignored; busy only in cycles 1..3
        exp_q.push_back(4'b0110);
        start = 1'b1;
        sin   = 1'b0;
        chk("t6_busy_c0", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        sin   = 1'b1;
        chk("t6_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b1;
        sin   = 1'b0;
        chk("t6_busy_c2", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        sin   = 1'b1;
        chk("t6_busy_c3", {31'd0, busy}, 32'd1);
        tick();
        sin = 1'b0;
        chk("t6_busy_c4", {31'd0, busy}, 32'd0);
        chk("t6_valid_c4", {31'd0, out_valid}, 32'd1);
        chk("t6_bin", {28'd0, bin_out}, 32'h6);
        tick();
        chk("t6_busy_c5", {31'd0, busy}, 32'd0);
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
